io_hub: RTL
===========

# io_hub

Parametrised memory-mapped I/O hub for the single-cycle MIPS core; it replaces the fixed 16-bit LED and 24-switch peripherals with one configurable block. It decodes a 32-byte window at `BASE_ADDR` on the CPU I/O bus. It provides:
- an LED data register with per-bit hardware blink;
- synchronised, optionally debounced switch inputs;
- a sticky switch-change register.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_FC60: byte address of register 0; must be 32-byte aligned.
- `LED_WIDTH`, 24: LED outputs, 1..32.
- `SW_WIDTH`, 24: switch inputs, 1..32.
- `DEB_CYCLES`, 20'd1_000_000: stable cycles required before a debounced switch bit changes; ≥1.
- `BLINK_DIV_RST`, 32'd25_000_000: reset value of BLINK_DIV.

Ports:
- `sys_clk` in 1: the single clock; all state is on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `ioread` in 1: CPU I/O read strobe.
- `iowrite` in 1: CPU I/O write strobe.
- `address` in 32: CPU byte address.
- `write_data` in 32: CPU store data.
- `read_data` out 32: load data, combinational.
- `io_sel` out 1: address falls in the window, i.e. `address[31:5] == BASE_ADDR[31:5]`.
- `sw_input` in SW_WIDTH: raw, asynchronous switches.
- `led` out LED_WIDTH: registered-source LED drive.

## Operation
Register map, selected by `address[4:2]`. Offsets 0x14–0x1C read 0 and ignore writes. `address[1:0]` is ignored.
- 0x00 LED_DATA (RW): LED_WIDTH bits.
- 0x04 BLINK_MASK (RW): 1 = that LED blinks.
- 0x08 SW_DATA (RO): filtered switch value.
- 0x0C SW_EDGE (RW1C): bit set on any change of the filtered bit; writing 1 clears it.
- 0x10 BLINK_DIV (RW): half-period of the blink, in cycles.

Width rules:
- Writes use the low register-width bits of `write_data`; upper bits are ignored.
- Reads are zero-extended to 32 bits.
- `read_data` = selected register when `ioread & io_sel`, else 0.
- A write occurs when `iowrite & io_sel`.

Switch path:
- `sw_input` passes through a 2-flop synchroniser per bit, then the filter.
- Filtered value `sw_f` resets to 0.
- Edge detect compares `sw_f` with its value from the previous cycle.
- If an edge and a W1C of the same bit occur in the same cycle, set wins.

Blink:
- A 32-bit prescaler counts up. When it equals BLINK_DIV it clears to 0 and toggles `phase`.
- `phase` resets to 1.
- BLINK_DIV = 0 freezes the prescaler at 0 and holds `phase` = 1, so blinking LEDs are solid on.
- A write to BLINK_DIV clears the prescaler and sets `phase` = 1 on the same edge.
- `led = LED_DATA & (~BLINK_MASK | {LED_WIDTH{phase}})`.

Reset values:
- LED_DATA, BLINK_MASK, SW_EDGE, prescaler, synchronisers, debounce counters: 0.
- BLINK_DIV: BLINK_DIV_RST.
- `led`: 0.
- `read_data`: 0.

Reset asserted mid-operation returns all state to these values immediately (asynchronous). Release takes effect on the next `sys_clk` edge.

## Timing
- Reads have zero latency: the value reflects register state before the current edge.
- Writes update registers at the clock edge ending the store cycle.
- `led` reflects a LED_DATA or BLINK_MASK write one cycle later.
- Switch to `sw_f` latency:
  - without debounce: 2 cycles;
  - with debounce: 2 + DEB_CYCLES cycles of continuous stability.
- SW_EDGE sets one cycle after `sw_f` changes.
- Blink period is 2 × (BLINK_DIV + 1) cycles.
- There is no handshake; the CPU never stalls.

## Configuration
Macro `IO_HUB_DEBOUNCE_EN`.
- **Defined:** each switch bit has a counter of width `$clog2(DEB_CYCLES+1)`.
  - The counter increments while the synchronised bit ≠ `sw_f` and clears when they are equal.
  - When the count reaches DEB_CYCLES, `sw_f` takes the synchronised bit and the counter clears.
  - A glitch shorter than DEB_CYCLES never reaches `sw_f`.
- **Undefined:** `sw_f` = synchroniser output; no counters are instantiated and DEB_CYCLES is unused.

## Structure
- Shared package `io_hub_pkg` holds:
  - register offset constants: REG_LED_DATA, REG_BLINK_MASK, REG_SW_DATA, REG_SW_EDGE, REG_BLINK_DIV;
  - the default BASE_ADDR.
- One sub-module, `io_debounce`: single-bit synchroniser plus optional filter, generated SW_WIDTH times.
- Register file, decode and blink logic stay in `io_hub`.

## Test plan
- **Reset:** hold `sys_rst_n` = 0 with `sw_input` = 24'hFFFFFF -> `led` = 0, SW_DATA read = 0, BLINK_DIV read = 25_000_000.
- **LED write/readback:** write 32'hABCD_EF12 to 0xFFFFFC60 -> `led` = 24'hCDEF12 next cycle; read returns 32'h00CDEF12; address 0xFFFFFC80 gives `io_sel` = 0 and no effect.
- **Blink:** BLINK_DIV = 3, BLINK_MASK = 24'h00000F, LED_DATA = 24'h0000FF -> `led` alternates 24'h0000FF / 24'h0000F0 every 4 cycles; writing BLINK_DIV = 0 -> steady 24'h0000FF.
- **Debounce (macro on, DEB_CYCLES = 8):**
  - `sw_input[0]` pulses high for 5 cycles -> SW_DATA stays 0, SW_EDGE stays 0.
  - Held high for 12 cycles -> SW_DATA[0] = 1 after 10 cycles; SW_EDGE[0] = 1 one cycle later.
- **W1C race:** write 32'h1 to SW_EDGE on the same cycle bit 0 toggles again -> SW_EDGE[0] remains 1; a later write of 32'h1 -> 0.
- **Unused offset:** read 0xFFFFFC74 -> 0; write there leaves all registers unchanged.

Source files
------------

// File: rtl/io_hub_pkg.sv
// io_hub_pkg: shared constants for the io_hub memory-mapped I/O block.
//   DEFAULT_BASE_ADDR : default byte address of register 0 (32-byte aligned).
//   REG_*             : byte offsets of the registers inside the 32-byte window.
package io_hub_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FC60;

    localparam logic [4:0] REG_LED_DATA   = 5'h00;
    localparam logic [4:0] REG_BLINK_MASK = 5'h04;
    localparam logic [4:0] REG_SW_DATA    = 5'h08;
    localparam logic [4:0] REG_SW_EDGE    = 5'h0C;
    localparam logic [4:0] REG_BLINK_DIV  = 5'h10;

endpackage

// File: rtl/io_hub_if.sv
// io_hub_if: CPU I/O bus between the core (master) and the I/O hub (slave).
//   ioread, iowrite : read / write strobes from the CPU
//   address         : CPU byte address
//   write_data      : CPU store data
//   read_data       : combinational load data from the hub
//   io_sel          : hub decodes the address into its window
interface io_hub_if;
    logic        ioread;
    logic        iowrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        io_sel;

    modport master (
        output ioread,
        output iowrite,
        output address,
        output write_data,
        input  read_data,
        input  io_sel
    );

    modport slave (
        input  ioread,
        input  iowrite,
        input  address,
        input  write_data,
        output read_data,
        output io_sel
    );
endinterface

// File: rtl/io_debounce.sv
// io_debounce: single-bit 2-flop synchroniser followed by an optional stability filter.
//   clk, rst_n : clock and asynchronous active-low reset
//   sw_raw     : raw asynchronous switch bit
//   sw_f       : filtered switch bit (resets to 0)
// Macro IO_HUB_DEBOUNCE_EN: when defined, sw_f only follows the synchronised bit after
// DEB_CYCLES consecutive cycles of disagreement; otherwise sw_f is the synchroniser output.
module io_debounce #(
    parameter int unsigned DEB_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_f
);

    if (DEB_CYCLES < 1) begin : g_deb_check
        $error("io_debounce: DEB_CYCLES must be at least 1");
    end

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef IO_HUB_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
    // The edge that would take the count to DEB_CYCLES updates sw_f instead.
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            sw_f_q;
    logic            sw_f_d;

    always_comb begin
        cnt_d  = '0;
        sw_f_d = sw_f_q;
        if (sync2_q != sw_f_q) begin
            if (cnt_q == CntLast) begin
                sw_f_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sw_f_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sw_f_q <= sw_f_d;
        end
    end

    assign sw_f = sw_f_q;
`else
    assign sw_f = sync2_q;
`endif

endmodule

// File: rtl/io_hub.sv
// io_hub: memory-mapped I/O hub on the CPU I/O bus, decoding a 32-byte window at BASE_ADDR.
//   sys_clk, sys_rst_n : clock and asynchronous active-low reset
//   bus                : CPU I/O bus (io_hub_if.slave), combinational read_data and io_sel
//   sw_input           : raw asynchronous switch inputs
//   led                : LED drive, LED_DATA gated by the blink phase on masked bits
// Registers (byte offset): 0x00 LED_DATA, 0x04 BLINK_MASK, 0x08 SW_DATA (RO),
// 0x0C SW_EDGE (W1C), 0x10 BLINK_DIV; 0x14-0x1C read 0.
// Macro IO_HUB_DEBOUNCE_EN enables the per-bit switch debounce filter in io_debounce.
module io_hub
    import io_hub_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int unsigned LED_WIDTH     = 24,
    parameter int unsigned SW_WIDTH      = 24,
    parameter int unsigned DEB_CYCLES    = 1_000_000,
    parameter logic [31:0] BLINK_DIV_RST = 32'd25_000_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    io_hub_if.slave              bus,
    input  logic [SW_WIDTH-1:0]  sw_input,
    output logic [LED_WIDTH-1:0] led
);

    if (LED_WIDTH < 1 || LED_WIDTH > 32) begin : g_led_check
        $error("io_hub: LED_WIDTH must be 1..32");
    end
    if (SW_WIDTH < 1 || SW_WIDTH > 32) begin : g_sw_check
        $error("io_hub: SW_WIDTH must be 1..32");
    end

    // Address decode; address[1:0] is ignored.
    logic [4:0] reg_off;
    logic       wr_en;
    logic       rd_en;
    logic       wr_led;
    logic       wr_mask;
    logic       wr_edge;
    logic       wr_div;

    assign bus.io_sel = (bus.address[31:5] == BASE_ADDR[31:5]);
    assign reg_off    = {bus.address[4:2], 2'b00};
    assign wr_en      = bus.iowrite & bus.io_sel;
    assign rd_en      = bus.ioread & bus.io_sel;
    assign wr_led     = wr_en && (reg_off == REG_LED_DATA);
    assign wr_mask    = wr_en && (reg_off == REG_BLINK_MASK);
    assign wr_edge    = wr_en && (reg_off == REG_SW_EDGE);
    assign wr_div     = wr_en && (reg_off == REG_BLINK_DIV);

    logic unused_bus;
    assign unused_bus = ^{bus.address[1:0], bus.write_data};

    // Switch path
    logic [SW_WIDTH-1:0] sw_f;
    logic [SW_WIDTH-1:0] sw_prev_q;
    logic [SW_WIDTH-1:0] sw_edge_q;
    logic [SW_WIDTH-1:0] sw_edge_d;
    logic [SW_WIDTH-1:0] w1c_mask;

    for (genvar i = 0; i < int'(SW_WIDTH); i++) begin : g_sw
        io_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk    (sys_clk),
            .rst_n  (sys_rst_n),
            .sw_raw (sw_input[i]),
            .sw_f   (sw_f[i])
        );
    end

    // A newly detected change wins over a simultaneous write-1-to-clear.
    always_comb begin
        w1c_mask  = wr_edge ? bus.write_data[SW_WIDTH-1:0] : '0;
        sw_edge_d = (sw_edge_q & ~w1c_mask) | (sw_f ^ sw_prev_q);
    end

    // Blink
    logic [LED_WIDTH-1:0] led_data_q;
    logic [LED_WIDTH-1:0] blink_mask_q;
    logic [31:0]          blink_div_q;
    logic [31:0]          prescaler_q;
    logic [31:0]          prescaler_d;
    logic                 phase_q;
    logic                 phase_d;

    always_comb begin
        prescaler_d = prescaler_q + 32'd1;
        phase_d     = phase_q;
        if (wr_div || (blink_div_q == 32'd0)) begin
            // Restart the pattern (or hold it solid on while the divider is 0).
            prescaler_d = 32'd0;
            phase_d     = 1'b1;
        end else if (prescaler_q == blink_div_q) begin
            prescaler_d = 32'd0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_data_q   <= '0;
            blink_mask_q <= '0;
            blink_div_q  <= BLINK_DIV_RST;
            prescaler_q  <= 32'd0;
            phase_q      <= 1'b1;
            sw_prev_q    <= '0;
            sw_edge_q    <= '0;
        end else begin
            if (wr_led) begin
                led_data_q <= bus.write_data[LED_WIDTH-1:0];
            end
            if (wr_mask) begin
                blink_mask_q <= bus.write_data[LED_WIDTH-1:0];
            end
            if (wr_div) begin
                blink_div_q <= bus.write_data;
            end
            prescaler_q <= prescaler_d;
            phase_q     <= phase_d;
            sw_prev_q   <= sw_f;
            sw_edge_q   <= sw_edge_d;
        end
    end

    assign led = led_data_q & (~blink_mask_q | {LED_WIDTH{phase_q}});

    // Zero-latency read mux
    always_comb begin
        bus.read_data = 32'd0;
        if (rd_en) begin
            case (reg_off)
                REG_LED_DATA:   bus.read_data = 32'(led_data_q);
                REG_BLINK_MASK: bus.read_data = 32'(blink_mask_q);
                REG_SW_DATA:    bus.read_data = 32'(sw_f);
                REG_SW_EDGE:    bus.read_data = 32'(sw_edge_q);
                REG_BLINK_DIV:  bus.read_data = blink_div_q;
                default:        bus.read_data = 32'd0;
            endcase
        end
    end

endmodule
